// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM states, instruction field positions and NOP word.
package instr_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int SH_HI = 10, SH_LO = 6;
    localparam int FN_HI = 5, FN_LO = 0;
    localparam int IMM_HI = 15, IMM_LO = 0;
    localparam int JA_HI = 25, JA_LO = 0;
endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: combinational split of an instruction word into its fields.
module instr_field_split
    import instr_fetch_pkg::*;
(
    input  logic [31:0] word,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr
);
    assign opcode = word[OP_HI:OP_LO];
    assign rs     = word[RS_HI:RS_LO];
    assign rt     = word[RT_HI:RT_LO];
    assign rd     = word[RD_HI:RD_LO];
    assign shamt  = word[SH_HI:SH_LO];
    assign funct  = word[FN_HI:FN_LO];
    assign imm16  = word[IMM_HI:IMM_LO];
    assign jaddr  = word[JA_HI:JA_LO];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM with PC, branch redirect and decoded-field output.
// Define INSTR_FETCH_TIMEOUT_EN to enable the imem_ack timeout and sticky fetch_err.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        fetch_err
);
    state_t      state, state_n;
    logic [31:0] pc, pc_n, ptgt, ptgt_n, iw, iw_n, pco, pco_n, tgt;
    logic        pend, pend_n, timeout, unused_ok;

    assign tgt       = {br_target[31:2], 2'b00};
    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    assign out_valid = state == HOLD;
    assign pc_out    = pco;

`ifdef INSTR_FETCH_TIMEOUT_EN
    logic [31:0] cnt, cnt_n;
    assign cnt_n     = (state == REQ && !imem_ack) ? cnt + 32'd1 : 32'd0;
    assign timeout   = state == REQ && !imem_ack && cnt_n == 32'(TIMEOUT_CYCLES);
    assign fetch_err = state == ERR;
    assign unused_ok = ^br_target[1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 32'd0;
        else     cnt <= cnt_n;
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
    assign unused_ok = ^{br_target[1:0], TIMEOUT_CYCLES == 0};
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ptgt_n  = ptgt;
        pend_n  = pend;
        iw_n    = iw;
        pco_n   = pco;
        case (state)
            IDLE: begin
                state_n = REQ;
                pc_n    = br_taken ? tgt : pc;
            end
            REQ: begin
                if (imem_ack) begin
                    // a redirect seen during this request (or with the ack) discards the word
                    if (pend || br_taken) begin
                        pc_n   = br_taken ? tgt : ptgt;
                        pend_n = 1'b0;
                    end else begin
                        iw_n    = imem_rdata;
                        pco_n   = pc;
                        pc_n    = pc + 32'd4;
                        state_n = HOLD;
                    end
                end else begin
                    pend_n  = pend | br_taken;
                    ptgt_n  = br_taken ? tgt : ptgt;
                    state_n = timeout ? ERR : REQ;
                end
            end
            HOLD: begin
                pc_n    = br_taken ? tgt : pc;
                state_n = (br_taken || out_ready) ? REQ : HOLD;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ptgt  <= 32'd0;
            pend  <= 1'b0;
            iw    <= NOP;
            pco   <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ptgt  <= ptgt_n;
            pend  <= pend_n;
            iw    <= iw_n;
            pco   <= pco_n;
        end
    end

    instr_field_split u_split (
        .word   (iw),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm16  (imm16),
        .jaddr  (jaddr)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a program-order model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, br_taken, out_valid, out_ready, fetch_err;
    logic [31:0] imem_addr, imem_rdata, br_target, pc_out;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic        req2, ack2, br2, valid2, ready2, err2;
    logic [31:0] addr2, rdata2, tgt2, pc2;
    logic [5:0]  op2, fn2;
    logic [4:0]  rs2, rt2, rd2, sh2;
    logic [15:0] imm2;
    logic [25:0] ja2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .br_taken(br_taken),
        .br_target(br_target), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr),
        .fetch_err(fetch_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .br_taken(br2),
        .br_target(tgt2), .out_valid(valid2), .out_ready(ready2),
        .pc_out(pc2), .opcode(op2), .rs(rs2), .rt(rt2), .rd(rd2),
        .shamt(sh2), .funct(fn2), .imm16(imm2), .jaddr(ja2),
        .fetch_err(err2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs;
        imem_ack = 0; imem_rdata = 0; br_taken = 0; br_target = 0; out_ready = 0;
        ack2 = 0; rdata2 = 0; br2 = 0; tgt2 = 0; ready2 = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 32; i++) begin
            if (imem_req) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1; imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++; if ({imem_req, out_valid, fetch_err} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b want=000", {imem_req, out_valid, fetch_err}); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got=%h want=0", pc_out); end
        checks++; if ({opcode, rs, rt, rd, shamt, funct, imm16, jaddr} !== '0) begin failures++; $display("FAIL reset_fields opcode=%h imm16=%h jaddr=%h want=0", opcode, imm16, jaddr); end
        checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_addr_wrap got=%h want=fffffffc", addr2); end
        rst = 0;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ack_in_reset_ignored out_valid got=%b want=0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        #2 rst = 1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL async_reset_abandon got req=%b want=0", imem_req); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_sequence;
        bit ok;
        logic [31:0] w;
        do_reset();
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            checks++; if (!ok) begin failures++; $display("FAIL seq_req_timeout k=%0d got no req want req", k); end
            checks++; if (imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL seq_addr k=%0d got=%h want=%h", k, imem_addr, 32'(4 * k)); end
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL seq_stable k=%0d req=%b addr=%h", k, imem_req, imem_addr); end
            @(negedge clk);
            w = mem(imem_addr);
            imem_ack = 1; imem_rdata = w;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL seq_early_valid k=%0d got=%b want=0", k, out_valid); end
            @(negedge clk);
            imem_ack = 0;
            checks++; if (out_valid !== 1'b1 || pc_out !== 32'(4 * k)) begin failures++; $display("FAIL seq_present k=%0d valid=%b pc_out=%h want 1 %h", k, out_valid, pc_out, 32'(4 * k)); end
            checks++; if (jaddr !== w[25:0] || opcode !== w[31:26]) begin failures++; $display("FAIL seq_fields k=%0d jaddr=%h opcode=%h want %h %h", k, jaddr, opcode, w[25:0], w[31:26]); end
        end
    endtask

    task automatic test_hold;
        bit ok;
        do_reset();
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_req_timeout got no req want req"); end
        imem_ack = 1; imem_rdata = 32'h2009_FFFC;
        @(negedge clk);
        imem_ack = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, imem_req, opcode, rs, rt, imm16} !== {1'b1, 1'b0, 6'h08, 5'd0, 5'd9, 16'hFFFC}) begin
                failures++; $display("FAIL hold_fields i=%0d valid=%b req=%b op=%h rs=%0d rt=%0d imm=%h want 1 0 08 0 9 fffc", i, out_valid, imem_req, opcode, rs, rt, imm16);
            end
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL hold_release valid=%b req=%b addr=%h want 0 1 4", out_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_req;
        bit ok;
        logic [31:0] w;
        do_reset();
        out_ready = 1;
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL brreq_req_timeout got no req want req"); end
        br_taken = 1; br_target = 32'h0000_0103;
        @(negedge clk);
        br_taken = 0; br_target = $urandom;
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL brreq_addr_stable got=%h want=0", imem_addr); end
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL brreq_discard valid=%b req=%b addr=%h want 0 1 100", out_valid, imem_req, imem_addr); end
        w = mem(32'h100);
        imem_ack = 1; imem_rdata = w;
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_valid !== 1'b1 || pc_out !== 32'h100 || imm16 !== w[15:0]) begin failures++; $display("FAIL brreq_present valid=%b pc_out=%h imm=%h want 1 100 %h", out_valid, pc_out, imm16, w[15:0]); end
    endtask

    task automatic test_redirect_hold;
        bit ok;
        do_reset();
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL brhold_req_timeout got no req want req"); end
        imem_ack = 1; imem_rdata = mem(32'h0);
        @(negedge clk);
        imem_ack = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL brhold_valid got=%b want=1", out_valid); end
        br_taken = 1; out_ready = 1; br_target = 32'h0000_0202;
        @(negedge clk);
        br_taken = 0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL brhold_redirect valid=%b req=%b addr=%h want 0 1 200", out_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        logic [31:0] q[$];
        do_reset();
        ready2 = 1;
        for (int i = 0; i < 20 && q.size() < 2; i++) begin
            @(negedge clk);
            ack2 = req2;
            rdata2 = mem(addr2);
            if (req2) q.push_back(addr2);
        end
        ack2 = 0;
        checks++; if (q.size() < 2) begin failures++; $display("FAIL wrap_fetch_count got=%0d want=2", q.size()); end
        else begin
            checks++; if (q[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%h want=fffffffc", q[0]); end
            checks++; if (q[1] !== 32'h0) begin failures++; $display("FAIL wrap_second got=%h want=0", q[1]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] mnext, prev_addr, w;
        bit prev_hold;
        int waitcnt, nacc;
        do_reset();
        mnext = 32'h0; prev_hold = 0; prev_addr = 0; waitcnt = 0; nacc = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin failures++; $display("FAIL rnd_stable c=%0d req=%b addr=%h want 1 %h", c, imem_req, imem_addr, prev_addr); end
            end
            if (out_valid) begin
                w = mem(pc_out);
                checks++; if ({opcode, rs, rt, rd, shamt, funct, imm16, jaddr} !== {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], w[15:0], w[25:0]}) begin
                    failures++; $display("FAIL rnd_fields c=%0d pc_out=%h op=%h rs=%h rt=%h rd=%h sh=%h fn=%h want word %h", c, pc_out, opcode, rs, rt, rd, shamt, funct, w);
                end
            end
            imem_ack = imem_req && ($urandom_range(0, 2) == 0 || waitcnt >= 3);
            waitcnt = (imem_req && !imem_ack) ? waitcnt + 1 : 0;
            imem_rdata = mem(imem_addr);
            br_taken = $urandom_range(0, 9) == 0;
            br_target = $urandom;
            out_ready = $urandom_range(0, 1) == 1;
            if (br_taken) mnext = {br_target[31:2], 2'b00};
            else if (out_valid && out_ready) begin
                checks++; if (pc_out !== mnext) begin failures++; $display("FAIL rnd_order c=%0d pc_out=%h want=%h", c, pc_out, mnext); end
                mnext = mnext + 32'd4;
                nacc++;
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
        idle_inputs();
        checks++; if (nacc < 20) begin failures++; $display("FAIL rnd_progress accepted=%0d want>=20", nacc); end
    endtask

    task automatic test_timeout;
        do_reset();
`ifdef INSTR_FETCH_TIMEOUT_EN
        begin
            int n;
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (imem_req) n++;
                else break;
            end
            checks++; if (n !== 16) begin failures++; $display("FAIL to_req_cycles got=%0d want=16", n); end
            checks++; if (fetch_err !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL to_err err=%b valid=%b req=%b want 1 0 0", fetch_err, out_valid, imem_req); end
            imem_ack = 1;
            repeat (5) @(negedge clk);
            imem_ack = 0;
            checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL to_sticky err=%b req=%b want 1 0", fetch_err, imem_req); end
            do_reset();
            checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL to_reset_clear err=%b want 0", fetch_err); end
        end
`else
        repeat (40) @(negedge clk);
        checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL no_timeout req=%b err=%b addr=%h want 1 0 0", imem_req, fetch_err, imem_addr); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_sequence();
        test_hold();
        test_redirect_req();
        test_redirect_hold();
        test_wrap();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
